// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop synchronizer, mid-bit sampling, optional even parity (UART_RX_PARITY_EN)
module uart_rx #(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             error,
  output logic             busy
);
  localparam int CW = $clog2(CLKDIV);
  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKDIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKDIV - 1);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d, data_q, data_d;
  logic             valid_q, valid_d, error_q, error_d;
  logic             rx_meta_q, rx_s_q;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
`endif
  assign data  = data_q;
  assign valid = valid_q;
  assign error = error_q;
  assign busy  = state_q != IDLE;
  // Next-state, counters, shift register and output pulses
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = rx_s_q ? IDLE : START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        shift_d = {rx_s_q, shift_q[WIDTH-1:1]};
        idx_d = idx_q + IW'(1);
`ifdef UART_RX_PARITY_EN
        state_d = (idx_q == LAST) ? PARITY : DATA;
`else
        state_d = (idx_q == LAST) ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt_q == FULL) begin
        cnt_d = '0;
        par_d = rx_s_q;
        state_d = STOP;
      end
`endif
      STOP: if (cnt_q == FULL) begin
        cnt_d = '0;
        state_d = rx_s_q ? IDLE : WAIT;
`ifdef UART_RX_PARITY_EN
        error_d = !rx_s_q || ^{shift_q, par_q};
`else
        error_d = !rx_s_q;
`endif
        valid_d = !error_d;
        data_d = valid_d ? shift_q : data_q;
      end
      WAIT: begin
        cnt_d = '0;
        state_d = rx_s_q ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers and input synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (WIDTH=8, CLKDIV=16)
module tb_uart_rx;
  localparam int CLKDIV = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LAT = 155 + (NB - 10) * CLKDIV;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] data;
  logic valid, error, busy;
  int cyc = 0, n_tests = 0, n_fail = 0, n_valid = 0, n_err = 0;
  logic both_seen = 1'b0;
  int vcyc[$];
  logic [7:0] vdat[$];
  uart_rx #(.WIDTH(8), .CLKDIV(CLKDIV)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid), .error(error), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Record every strobe away from the clock edge
  always @(negedge clk) begin
    if (valid) begin
      n_valid <= n_valid + 1;
      vcyc.push_back(cyc);
      vdat.push_back(data);
    end
    if (error) n_err <= n_err + 1;
    if (valid && error) both_seen <= 1'b1;
  end
  function automatic logic [11:0] frame(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    return {1'b0, stop, ^d, d, 1'b0};
`else
    return {2'b00, stop, d, 1'b0};
`endif
  endfunction
  task automatic send_bits(input logic [11:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      rx = b[i];
      repeat (CLKDIV) @(negedge clk);
    end
  endtask
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    n_tests += 4;
    if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data); end
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid); end
    if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", error); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    idle(4);
  endtask
  task automatic test_single;
    int v0 = n_valid, e0 = n_err, s = cyc, t;
    vcyc.delete();
    vdat.delete();
    send_bits(frame(8'hA5, 1'b1), NB);
    idle(16);
    t = vcyc.size() > 0 ? vcyc[0] : -1;
    n_tests += 4;
    if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", n_valid - v0); end
    if (data !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%h exp=a5", data); end
    if (t !== s + LAT) begin n_fail++; $display("FAIL single_time got=%0d exp=%0d", t, s + LAT); end
    if (n_err - e0 !== 0) begin n_fail++; $display("FAIL single_err got=%0d exp=0", n_err - e0); end
  endtask
  task automatic test_back_to_back;
    logic [7:0] exp_d [3] = '{8'h00, 8'hFF, 8'h3C};
    int v0 = n_valid, e0 = n_err, d1, d2;
    vcyc.delete();
    vdat.delete();
    for (int i = 0; i < 3; i++) send_bits(frame(exp_d[i], 1'b1), NB);
    idle(16);
    d1 = vcyc.size() == 3 ? vcyc[1] - vcyc[0] : -1;
    d2 = vcyc.size() == 3 ? vcyc[2] - vcyc[1] : -1;
    n_tests += 4;
    if (n_valid - v0 !== 3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", n_valid - v0); end
    if (n_err - e0 !== 0) begin n_fail++; $display("FAIL b2b_err got=%0d exp=0", n_err - e0); end
    if (d1 !== NB * CLKDIV) begin n_fail++; $display("FAIL b2b_gap1 got=%0d exp=%0d", d1, NB * CLKDIV); end
    if (d2 !== NB * CLKDIV) begin n_fail++; $display("FAIL b2b_gap2 got=%0d exp=%0d", d2, NB * CLKDIV); end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] g;
      g = vdat.size() > i ? vdat[i] : 8'hxx;
      n_tests++;
      if (g !== exp_d[i]) begin n_fail++; $display("FAIL b2b_data%0d got=%h exp=%h", i, g, exp_d[i]); end
    end
  endtask
  task automatic test_glitch;
    int v0 = n_valid, e0 = n_err;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_hi got=%b exp=1", busy); end
    @(negedge clk);
    idle(20);
    n_tests += 3;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_lo got=%b exp=0", busy); end
    if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL glitch_valid got=%0d exp=0", n_valid - v0); end
    if (n_err - e0 !== 0) begin n_fail++; $display("FAIL glitch_err got=%0d exp=0", n_err - e0); end
  endtask
  task automatic test_framing;
    int v0 = n_valid, e0 = n_err;
    logic [7:0] prev = data;
    send_bits(frame(8'h55, 1'b0), NB);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    n_tests += 4;
    if (n_err - e0 !== 1) begin n_fail++; $display("FAIL frm_err got=%0d exp=1", n_err - e0); end
    if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL frm_valid got=%0d exp=0", n_valid - v0); end
    if (data !== prev) begin n_fail++; $display("FAIL frm_data_hold got=%h exp=%h", data, prev); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL frm_wait_busy got=%b exp=1", busy); end
    idle(16);
    send_bits(frame(8'h12, 1'b1), NB);
    idle(16);
    n_tests += 2;
    if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL frm_next_valid got=%0d exp=1", n_valid - v0); end
    if (data !== 8'h12) begin n_fail++; $display("FAIL frm_next_data got=%h exp=12", data); end
  endtask
  task automatic test_reset_mid;
    int v0 = n_valid, e0 = n_err;
    send_bits(frame(8'h81, 1'b1), 5);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests += 2;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    if (data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data got=%h exp=00", data); end
    idle(32);
    n_tests++;
    if (n_valid + n_err - v0 - e0 !== 0) begin n_fail++; $display("FAIL rstmid_pulse got=%0d exp=0", n_valid + n_err - v0 - e0); end
    send_bits(frame(8'h42, 1'b1), NB);
    idle(16);
    n_tests += 2;
    if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL rstmid_valid got=%0d exp=1", n_valid - v0); end
    if (data !== 8'h42) begin n_fail++; $display("FAIL rstmid_next_data got=%h exp=42", data); end
  endtask
`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0 = n_valid, e0 = n_err;
    send_bits({1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    idle(16);
    n_tests += 2;
    if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL par_ok_valid got=%0d exp=1", n_valid - v0); end
    if (data !== 8'h07) begin n_fail++; $display("FAIL par_ok_data got=%h exp=07", data); end
    send_bits({1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    idle(16);
    n_tests += 3;
    if (n_err - e0 !== 1) begin n_fail++; $display("FAIL par_bad_err got=%0d exp=1", n_err - e0); end
    if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL par_bad_valid got=%0d exp=1", n_valid - v0); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL par_bad_busy got=%b exp=0", busy); end
  endtask
`endif
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_framing;
    test_reset_mid;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    n_tests++;
    if (both_seen !== 1'b0) begin n_fail++; $display("FAIL valid_and_error got=%b exp=0", both_seen); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive counterpart of the team's `uart_tx` transmitter. It samples an idle-high serial line carrying 8N1-style frames: start bit 0, WIDTH data bits LSB first, stop bit 1, with a fixed CLKDIV clocks per bit. It presents each received word on a parallel bus with a one-cycle valid strobe. It sits between an FPGA input pin and the consuming logic (command decoder, FIFO).

## Interface
- `WIDTH`, default 8: data bits per frame.
- `CLKDIV`, default 16: clock cycles per bit. Must be ≥ 4. Must match the transmitter's CLKDIV.

- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  serial line; asynchronous to `clk`; idle high.
- `data`  out  WIDTH  last correctly received word; LSB is the first bit on the wire.
- `valid`  out  1  one-cycle pulse; `data` is new on that cycle.
- `error`  out  1  one-cycle pulse on a framing error (or parity error, see Configuration).
- `busy`  out  1  high while a frame is being received, i.e. state ≠ IDLE.

## Operation
- **Input synchronizer.** `rx` passes through two flops (`rx_s`). Both flops reset to 1. All decisions below use `rx_s`.
- **Counters.**
  - Bit-period counter of width `$clog2(CLKDIV)`.
  - Bit index counter of width `$clog2(WIDTH+1)`.
  - Shift register of WIDTH bits, filled from the MSB end by right shift, so the first bit received ends up in the LSB.
- **State machine:**
  - **IDLE:** when `rx_s`==0, clear the counter and go to START.
  - **START:** when the counter reaches CLKDIV/2−1 (mid start bit):
    - if `rx_s`==0, clear the counter and index, then go to DATA;
    - otherwise it was a glitch: return to IDLE with no output.
  - **DATA:** each time the counter reaches CLKDIV−1, shift in `rx_s` and increment the index. After WIDTH bits, go to STOP.
  - **STOP:** when the counter reaches CLKDIV−1:
    - if `rx_s`==1, load `data` from the shift register, pulse `valid`, and go to IDLE;
    - if `rx_s`==0, pulse `error`, leave `data` unchanged, and go to WAIT.
  - **WAIT:** stay until `rx_s`==1, then go to IDLE. This absorbs break conditions.
- **Output behaviour:**
  - `data` holds its value between frames.
  - `valid` and `error` are never high on the same cycle.
- **Reset values:** `data`=0, `valid`=0, `error`=0, `busy`=0, state=IDLE, synchronizer flops=1.
- **Reset mid-frame:** the partial frame is discarded and no pulse is emitted. Reception restarts at the next falling edge seen in IDLE.

## Timing
- Define t0 as the first cycle on which `rx_s`==0 in IDLE. t0 is 2–3 cycles after the pin edge.
- Start bit is checked at t0+CLKDIV/2.
- Data bit i is sampled at t0 + CLKDIV/2 + (i+1)·CLKDIV.
- Stop bit is sampled at t0 + CLKDIV/2 + (WIDTH+1)·CLKDIV.
- `valid`/`error` are registered and high on the cycle after the stop sample.
- **Back-to-back frames:** IDLE is re-entered about half a bit before the stop bit ends, so a start edge immediately following the stop bit is caught with no loss.
- **Baud tolerance:** sampling at mid-bit tolerates roughly ±4% total clock mismatch over a 10-bit frame.
- `busy` rises the cycle after t0. It falls on the cycle `valid` pulses, or when WAIT/START exits to IDLE.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:**
  - One even-parity bit is expected after the data bits and before the stop bit, sampled at mid-bit in an added PARITY state. The frame becomes WIDTH+3 bits long, and the stop sample moves one CLKDIV later.
  - Parity mismatch: when the stop sample is 1, `error` pulses instead of `valid`, `data` is not updated, and the receiver returns to IDLE. When the stop sample is 0, it is a framing error and is handled as in STOP (go to WAIT).
- **Undefined:** no PARITY state. The frame is exactly start + WIDTH + stop.

## Test plan
- **Single frame:** reset, then drive frame 0xA5 with CLKDIV=16 → exactly one `valid` pulse, `data`=0xA5 at t0+8+9·16+1, `error` never high.
- **Back-to-back:** frames 0x00, 0xFF, 0x3C with no idle between them → three `valid` pulses in order with the correct data, spaced 160 cycles apart.
- **Glitch:** `rx` low for 5 cycles, then high → `busy` returns low, no `valid`, no `error`.
- **Framing error:** frame 0x55 with stop bit driven 0, then line held low for 40 cycles, then frame 0x12 → one `error` pulse, `data` stays 0x55's predecessor, then `valid` with `data`=0x12.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 4 of 0x81, then send 0x42 → no pulse for the aborted frame, then `valid` with `data`=0x42.
- **With `UART_RX_PARITY_EN`:**
  - 0x07 with parity 1 → `valid`, `data`=0x07.
  - 0x07 with parity 0 → `error`, no `valid`.
